sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: NPORTS, 3, number of requester ports; only value 3 is supported.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  asynchronous reset, active-high.
REQ-004 Port: m_rd  input  3  per-port read request, bit i = port i; level, held until ack.
REQ-005 Port: m_wr  input  3  per-port write request, bit i = port i; level, held until ack.
REQ-006 Port: m_addr  input  51  per-port word address, port i at bits [17i+16:17i].
REQ-007 Port: m_wdata  input  48  per-port write data, port i at bits [16i+15:16i].
REQ-008 Port: m_ack  output  3  one-cycle completion pulse to the owning port.
REQ-009 Port: m_rdata  output  16  read data; valid in the m_ack cycle of a read.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.
REQ-011 Port: owner  output  2  index of the current/last granted port.
REQ-012 Port: ctl_read_req  output  1  read strobe to the SRAM controller.
REQ-013 Port: ctl_write_req  output  1  write strobe to the SRAM controller.
REQ-014 Port: ctl_addr  output  17  address to the controller; stable for the whole operation.
REQ-015 Port: ctl_wdata  output  16  write data to the controller; stable for the whole operation.
REQ-016 Port: ctl_read_data  input  16  read data from the controller, valid with ctl_ready.
REQ-017 Port: ctl_ready  input  1  controller one-cycle completion pulse.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, DONE; registered state, transitions on clk.
REQ-019 IDLE: port i is pending if m_rd[i] or m_wr[i]; if any port is pending, select a winner, register owner, address, data and operation (read if m_rd set, else write), then go to ISSUE; otherwise stay in IDLE.
REQ-020 A port asserting both m_rd and m_wr is treated as a read; the write remains pending only if it is held after the ack.
REQ-021 ISSUE: assert ctl_read_req or ctl_write_req for exactly one cycle, then go to WAIT.
REQ-022 WAIT: both strobes low; ctl_addr/ctl_wdata held; on ctl_ready, capture ctl_read_data into m_rdata (reads only) and go to DONE; no timeout.
REQ-023 DONE: m_ack[owner]=1 for this single cycle; all requests ignored; next state IDLE.
REQ-024 A requester shall deassert its request no later than the cycle after m_ack; a request still high in IDLE is a new operation.
REQ-025 Minimum grant-to-grant spacing: IDLE→ISSUE→WAIT(≥1)→DONE→IDLE, i.e. ≥4 cycles.
REQ-026 Request changes from non-owner ports during ISSUE/WAIT/DONE do not affect the operation in flight.
REQ-027 m_rdata holds its last read value through writes and idle cycles.
REQ-028 ctl_ready outside WAIT is ignored.

Reset
REQ-029 On rst: state=IDLE; m_ack=0; ctl_read_req=0; ctl_write_req=0; ctl_addr=0; ctl_wdata=0; m_rdata=0; owner=0; busy=0; round-robin pointer=0.
REQ-030 Reset mid-operation aborts without ack; the first grant after reset follows REQ-029 pointer state.

Configuration
REQ-031 Macro SRAM_ARB_ROUND_ROBIN_EN defined: the winner is the first pending port searching from (last owner+1) mod 3 upward; after reset the search starts at port 0.
REQ-032 Macro SRAM_ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 > port 1 > port 2; the pointer is not implemented.

Verification
REQ-033 Port 1 writes addr 0x00123 data 0xBEEF, then reads 0x00123; controller model returns 0xBEEF -> two m_ack[1] pulses, m_rdata=0xBEEF, ctl_addr=0x00123 constant across both WAIT states.
REQ-034 Ports 0, 1 and 2 all read continuously, with RR enabled -> grant order 0,1,2,0,1,2; with RR disabled -> only port 0 is served while it holds its request.
REQ-035 Port 2 sets m_rd and m_wr together at addr 0x1FFFF -> ctl_read_req pulses and ctl_write_req stays 0.
REQ-036 ctl_ready delayed by 20 cycles while port 0 toggles addr -> ctl_addr unchanged, busy=1 throughout, single m_ack[0] in the cycle after ctl_ready.
REQ-037 rst asserted during WAIT -> all outputs at reset values in the same cycle, no m_ack; after release, a pending port 1 request is granted normally.
REQ-038 Spurious ctl_ready in IDLE -> no m_ack and no state change.

Source files
------------

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares one SRAM controller between three requester ports. A grant latches
// the winner's address, write data and operation, issues a one-cycle strobe to
// the controller, waits (unbounded) for the controller's completion pulse,
// then returns a one-cycle ack to the owning port.
//
// Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN
//   defined   : round-robin arbitration, search starts at (last owner + 1) mod 3
//   undefined : fixed priority, port 0 > port 1 > port 2
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   m_rd, m_wr      : per-port read/write request levels, held until ack
//   m_addr          : per-port 17-bit word address, port i at [17i+16:17i]
//   m_wdata         : per-port 16-bit write data, port i at [16i+15:16i]
//   m_ack           : one-cycle completion pulse to the owning port
//   m_rdata         : read data, valid in the ack cycle of a read, held after
//   busy            : high whenever the FSM is not IDLE
//   owner           : index of the current / last granted port
//   ctl_read_req    : one-cycle read strobe to the controller
//   ctl_write_req   : one-cycle write strobe to the controller
//   ctl_addr        : controller address, stable for the whole operation
//   ctl_wdata       : controller write data, stable for the whole operation
//   ctl_read_data   : controller read data, valid with ctl_ready
//   ctl_ready       : controller one-cycle completion pulse
//   dbg_state       : current FSM state encoding (IDLE=0 ISSUE=1 WAIT=2 DONE=3)
//
// Handshake: a requester raises m_rd/m_wr and holds it (with its address and
// data) until it sees m_ack; it drops the request in the ack cycle or the one
// right after. A request still high when the FSM is back in IDLE is taken as
// a new operation. On the controller side the strobe is a single-cycle pulse
// and ctl_ready is honoured only in WAIT.
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int NPORTS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NPORTS-1:0]     m_rd,
    input  logic [NPORTS-1:0]     m_wr,
    input  logic [17*NPORTS-1:0]  m_addr,
    input  logic [16*NPORTS-1:0]  m_wdata,
    output logic [NPORTS-1:0]     m_ack,
    output logic [15:0]           m_rdata,
    output logic                  busy,
    output logic [1:0]            owner,
    output logic                  ctl_read_req,
    output logic                  ctl_write_req,
    output logic [16:0]           ctl_addr,
    output logic [15:0]           ctl_wdata,
    input  logic [15:0]           ctl_read_data,
    input  logic                  ctl_ready,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic [16:0]         addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                is_read_q, is_read_d;
    logic                rd_req_q, rd_req_d;
    logic                wr_req_q, wr_req_d;
    logic [NPORTS-1:0]   ack_q, ack_d;
    logic [15:0]         rdata_q, rdata_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic [1:0]          rr_ptr_q, rr_ptr_d;
`endif

    logic [NPORTS-1:0]   pending;
    logic                any_pending;
    logic [1:0]          winner;
    logic [16:0]         sel_addr;
    logic [15:0]         sel_wdata;

    assign pending     = m_rd | m_wr;
    assign any_pending = |pending;

    // Winner selection. The loop walks from the lowest-priority candidate to
    // the highest so the last match (the highest priority) sticks.
    always_comb begin
        winner = 2'd0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        for (int k = NPORTS - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NPORTS;
            if (pending[idx]) begin
                winner = 2'(idx);
            end
        end
`else
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (pending[k]) begin
                winner = 2'(k);
            end
        end
`endif
    end

    assign sel_addr  = m_addr[17*winner +: 17];
    assign sel_wdata = m_wdata[16*winner +: 16];

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_read_d = is_read_q;
        rdata_d   = rdata_q;
        rd_req_d  = 1'b0;
        wr_req_d  = 1'b0;
        ack_d     = '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_pending) begin
                    state_d   = ISSUE;
                    owner_d   = winner;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    // Read wins when a port raises both requests.
                    is_read_d = m_rd[winner];
                    rd_req_d  = m_rd[winner];
                    wr_req_d  = ~m_rd[winner];
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    rr_ptr_d  = (winner == 2'd2) ? 2'd0 : winner + 2'd1;
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (ctl_ready) begin
                    state_d        = DONE;
                    ack_d[owner_q] = 1'b1;
                    if (is_read_q) begin
                        rdata_d = ctl_read_data;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_read_q <= 1'b0;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            ack_q     <= '0;
            rdata_q   <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            rr_ptr_q  <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_read_q <= is_read_d;
            rd_req_q  <= rd_req_d;
            wr_req_q  <= wr_req_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
        end
    end

    assign m_ack         = ack_q;
    assign m_rdata       = rdata_q;
    assign busy          = (state_q != IDLE);
    assign owner         = owner_q;
    assign ctl_read_req  = rd_req_q;
    assign ctl_write_req = wr_req_q;
    assign ctl_addr      = addr_q;
    assign ctl_wdata     = wdata_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Directed scenarios for sram_arbiter. Inputs are driven and outputs sampled
// on the falling clock edge. The bench plays the SRAM controller by hand:
// it waits for a strobe, optionally stalls, then pulses ctl_ready.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  m_rd;
  logic [2:0]  m_wr;
  logic [50:0] m_addr;
  logic [47:0] m_wdata;
  logic [2:0]  m_ack;
  logic [15:0] m_rdata;
  logic        busy;
  logic [1:0]  owner;
  logic        ctl_read_req;
  logic        ctl_write_req;
  logic [16:0] ctl_addr;
  logic [15:0] ctl_wdata;
  logic [15:0] ctl_read_data;
  logic        ctl_ready;
  logic [1:0]  dbg_state;

  int checks = 0;
  int passed = 0;

  logic [1:0] exp_q[$];

  sram_arbiter #(.NPORTS(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .m_rd          (m_rd),
    .m_wr          (m_wr),
    .m_addr        (m_addr),
    .m_wdata       (m_wdata),
    .m_ack         (m_ack),
    .m_rdata       (m_rdata),
    .busy          (busy),
    .owner         (owner),
    .ctl_read_req  (ctl_read_req),
    .ctl_write_req (ctl_write_req),
    .ctl_addr      (ctl_addr),
    .ctl_wdata     (ctl_wdata),
    .ctl_read_data (ctl_read_data),
    .ctl_ready     (ctl_ready),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic [16:0] a, input logic [15:0] d);
    m_addr[17*p +: 17]  = a;
    m_wdata[16*p +: 16] = d;
  endtask

  // Wait (bounded) until either controller strobe is visible.
  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ctl_read_req || ctl_write_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic ready_pulse(input logic [15:0] d);
    ctl_read_data = d;
    ctl_ready     = 1'b1;
    @(negedge clk);
    ctl_ready     = 1'b0;
    ctl_read_data = 16'h0000;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    m_rd = '0; m_wr = '0; m_addr = '0; m_wdata = '0;
    ctl_ready = 1'b0; ctl_read_data = '0;
    tick(2);
    checks++;
    if ({m_ack, ctl_read_req, ctl_write_req, busy, owner, dbg_state} !== 10'b0)
      $display("FAIL reset_ctrl: got ack=%b rd=%b wr=%b busy=%b owner=%0d st=%0d, expected all 0",
               m_ack, ctl_read_req, ctl_write_req, busy, owner, dbg_state);
    else passed++;
    checks++;
    if ({ctl_addr, ctl_wdata, m_rdata} !== 49'b0)
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, expected 0", ctl_addr, ctl_wdata, m_rdata);
    else passed++;
    rst = 1'b0;
    tick(2);
    checks++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b expected 0", busy);
    else passed++;
  endtask

  task automatic test_write_read();
    bit ok;
    set_port(1, 17'h00123, 16'hBEEF);
    m_wr[1] = 1'b1;
    wait_strobe(ok);
    checks++;
    if (ok !== 1'b1) $display("FAIL wr_grant_timeout: no strobe seen");
    else passed++;
    checks++;
    if ({ctl_write_req, ctl_read_req, owner, busy} !== {1'b1, 1'b0, 2'd1, 1'b1})
      $display("FAIL wr_issue: got wr=%b rd=%b owner=%0d busy=%b, expected 1 0 1 1",
               ctl_write_req, ctl_read_req, owner, busy);
    else passed++;
    checks++;
    if ({ctl_addr, ctl_wdata} !== {17'h00123, 16'hBEEF})
      $display("FAIL wr_payload: got addr=%h wdata=%h, expected 00123 beef", ctl_addr, ctl_wdata);
    else passed++;
    tick();
    checks++;
    if ({ctl_write_req, ctl_read_req} !== 2'b00)
      $display("FAIL wr_strobe_once: got wr=%b rd=%b, expected 0 0", ctl_write_req, ctl_read_req);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ctl_addr !== 17'h00123) $display("FAIL wr_wait_addr: got %h expected 00123", ctl_addr);
      else passed++;
    end
    // Read data offered on a write completion must not be captured.
    ready_pulse(16'hDEAD);
    checks++;
    if ({m_ack, m_rdata} !== {3'b010, 16'h0000})
      $display("FAIL wr_ack: got ack=%b rdata=%h, expected 010 0000", m_ack, m_rdata);
    else passed++;
    m_wr[1] = 1'b0;
    tick();
    checks++;
    if ({m_ack, busy} !== 4'b0000) $display("FAIL wr_ack_single: got ack=%b busy=%b, expected 000 0", m_ack, busy);
    else passed++;

    m_rd[1] = 1'b1;
    wait_strobe(ok);
    checks++;
    if ({ok, ctl_read_req, ctl_write_req, ctl_addr} !== {1'b1, 1'b1, 1'b0, 17'h00123})
      $display("FAIL rd_issue: got ok=%b rd=%b wr=%b addr=%h, expected 1 1 0 00123",
               ok, ctl_read_req, ctl_write_req, ctl_addr);
    else passed++;
    tick();
    checks++;
    if (ctl_addr !== 17'h00123) $display("FAIL rd_wait_addr: got %h expected 00123", ctl_addr);
    else passed++;
    ready_pulse(16'hBEEF);
    checks++;
    if ({m_ack, m_rdata} !== {3'b010, 16'hBEEF})
      $display("FAIL rd_ack: got ack=%b rdata=%h, expected 010 beef", m_ack, m_rdata);
    else passed++;
    m_rd[1] = 1'b0;
    tick();
  endtask

  task automatic test_dual_request();
    bit ok;
    set_port(2, 17'h1FFFF, 16'h4242);
    m_rd[2] = 1'b1;
    m_wr[2] = 1'b1;
    wait_strobe(ok);
    checks++;
    if ({ok, ctl_read_req, ctl_write_req, owner, ctl_addr} !== {1'b1, 1'b1, 1'b0, 2'd2, 17'h1FFFF})
      $display("FAIL dual_issue: got ok=%b rd=%b wr=%b owner=%0d addr=%h, expected 1 1 0 2 1ffff",
               ok, ctl_read_req, ctl_write_req, owner, ctl_addr);
    else passed++;
    tick();
    checks++;
    if (ctl_write_req !== 1'b0) $display("FAIL dual_no_write: wr=%b expected 0", ctl_write_req);
    else passed++;
    ready_pulse(16'h0F0F);
    checks++;
    if ({m_ack, m_rdata} !== {3'b100, 16'h0F0F})
      $display("FAIL dual_ack: got ack=%b rdata=%h, expected 100 0f0f", m_ack, m_rdata);
    else passed++;
    m_rd[2] = 1'b0;
    m_wr[2] = 1'b0;
    tick();
  endtask

  task automatic test_slow_ready();
    bit ok;
    int bad;
    set_port(0, 17'h00ABC, 16'h0000);
    m_rd[0] = 1'b1;
    wait_strobe(ok);
    checks++;
    if ({ok, ctl_addr} !== {1'b1, 17'h00ABC})
      $display("FAIL slow_issue: got ok=%b addr=%h, expected 1 00abc", ok, ctl_addr);
    else passed++;
    tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      m_addr[16:0] = 17'(17'h111 * (i + 1));
      tick();
      if ({ctl_addr, busy, m_ack} !== {17'h00ABC, 1'b1, 3'b000}) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL slow_hold: %0d stall cycles with addr/busy/ack wrong, expected 0", bad);
    else passed++;
    ready_pulse(16'h1234);
    checks++;
    if ({m_ack, m_rdata} !== {3'b001, 16'h1234})
      $display("FAIL slow_ack: got ack=%b rdata=%h, expected 001 1234", m_ack, m_rdata);
    else passed++;
    m_rd[0] = 1'b0;
    tick();
    checks++;
    if (m_ack !== 3'b000) $display("FAIL slow_ack_single: ack=%b expected 000", m_ack);
    else passed++;
  endtask

  task automatic test_spurious_ready();
    tick();
    ready_pulse(16'h5555);
    checks++;
    if ({m_ack, busy, ctl_read_req, ctl_write_req, m_rdata} !== {3'b000, 1'b0, 1'b0, 1'b0, 16'h1234})
      $display("FAIL spurious: got ack=%b busy=%b rd=%b wr=%b rdata=%h, expected 000 0 0 0 1234",
               m_ack, busy, ctl_read_req, ctl_write_req, m_rdata);
    else passed++;
    tick();
    checks++;
    if ({busy, dbg_state} !== 3'b000) $display("FAIL spurious_state: busy=%b st=%0d expected 0 0", busy, dbg_state);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_port(1, 17'h00777, 16'h0000);
    m_rd[1] = 1'b1;
    wait_strobe(ok);
    tick();
    checks++;
    if ({ok, busy, dbg_state} !== {1'b1, 1'b1, 2'd2})
      $display("FAIL rstmid_wait: got ok=%b busy=%b st=%0d, expected 1 1 2", ok, busy, dbg_state);
    else passed++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({m_ack, ctl_read_req, ctl_write_req, busy, owner, ctl_addr, ctl_wdata, m_rdata} !== 57'b0)
      $display("FAIL rstmid_clear: ack=%b rd=%b wr=%b busy=%b owner=%0d addr=%h wdata=%h rdata=%h, expected all 0",
               m_ack, ctl_read_req, ctl_write_req, busy, owner, ctl_addr, ctl_wdata, m_rdata);
    else passed++;
    tick(2);
    rst = 1'b0;
    wait_strobe(ok);
    checks++;
    if ({ok, ctl_read_req, owner, ctl_addr} !== {1'b1, 1'b1, 2'd1, 17'h00777})
      $display("FAIL rstmid_regrant: got ok=%b rd=%b owner=%0d addr=%h, expected 1 1 1 00777",
               ok, ctl_read_req, owner, ctl_addr);
    else passed++;
    tick();
    ready_pulse(16'h7777);
    checks++;
    if ({m_ack, m_rdata} !== {3'b010, 16'h7777})
      $display("FAIL rstmid_ack: got ack=%b rdata=%h, expected 010 7777", m_ack, m_rdata);
    else passed++;
    m_rd[1] = 1'b0;
    tick();
  endtask

  task automatic test_all_read();
    bit ok;
    logic [1:0] exp_owner;
    logic [2:0] exp_ack;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int p = 0; p < 3; p++) set_port(p, 17'(17'h100 + p), 16'h0000);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    for (int n = 0; n < 6; n++) exp_q.push_back(2'(n % 3));
`else
    for (int n = 0; n < 6; n++) exp_q.push_back(2'd0);
`endif
    m_rd = 3'b111;
    for (int n = 0; n < 6; n++) begin
      exp_owner = exp_q.pop_front();
      exp_ack   = 3'b001 << exp_owner;
      wait_strobe(ok);
      checks++;
      if ({ok, owner, ctl_addr} !== {1'b1, exp_owner, 17'(17'h100 + exp_owner)})
        $display("FAIL all_grant[%0d]: got ok=%b owner=%0d addr=%h, expected 1 %0d %h",
                 n, ok, owner, ctl_addr, exp_owner, 17'(17'h100 + exp_owner));
      else passed++;
      tick();
      ready_pulse(16'(16'hA000 + n));
      checks++;
      if ({m_ack, m_rdata} !== {exp_ack, 16'(16'hA000 + n)})
        $display("FAIL all_ack[%0d]: got ack=%b rdata=%h, expected %b %h",
                 n, m_ack, m_rdata, exp_ack, 16'(16'hA000 + n));
      else passed++;
    end
    m_rd = 3'b000;
    tick(2);
    checks++;
    if (busy !== 1'b0) $display("FAIL all_drain: busy=%b expected 0", busy);
    else passed++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_dual_request();
    test_slow_ready();
    test_spurious_ready();
    test_reset_mid();
    test_all_read();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
